// File: rtl/imem_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : imem_line_fetcher
//  Purpose  : Instruction-memory load unit sitting just upstream of the fetch
//             unit. Serves single-instruction loads from a one-line buffer and
//             refills the whole line from backing memory on a miss. A branch
//             redirect (flush_i) suppresses any response still owed.
//  Ports    : clk, rst               - clock, synchronous active-high reset
//             load_addr_i/load_en_i  - fetch-side load request
//             load_insn_o/load_rdy_o - returned instruction and its strobe
//             load_busy_o            - unit cannot accept a request
//             flush_i                - redirect, kills pending response
//             mem_req_o/mem_addr_o   - line refill request, line base address
//             mem_gnt_i              - refill request accepted
//             mem_rvalid_i/mem_rdata_i - in-order refill beats
//  Revision : 1.0 - initial release
// ============================================================================
module imem_line_fetcher #(
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] load_addr_i,
  input  logic                  load_en_i,
  output logic [31:0]           load_insn_o,
  output logic                  load_busy_o,
  output logic                  load_rdy_o,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int OFF_BITS  = WORD_BITS + 2;
  localparam int TAG_BITS  = DATA_WIDTH - OFF_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_line_valid;
  logic [TAG_BITS-1:0]   r_line_tag;
  logic [31:0]           r_line [LINE_WORDS];
  logic [WORD_BITS-1:0]  r_beat;
  logic [WORD_BITS-1:0]  r_word;
  logic [TAG_BITS-1:0]   r_req_tag;
  logic                  r_drop;
  logic [31:0]           r_insn_hold;
  logic                  r_mem_req;
  logic [DATA_WIDTH-1:0] r_mem_addr;

  logic [TAG_BITS-1:0]   w_tag;
  logic [WORD_BITS-1:0]  w_word;
  logic                  w_hit;
  logic                  w_last_beat;
  logic                  w_rdy;
  logic                  w_unused_addr_bits;

  assign w_tag       = load_addr_i[DATA_WIDTH-1:OFF_BITS];
  assign w_word      = load_addr_i[OFF_BITS-1:2];
  assign w_hit       = r_line_valid && (r_line_tag == w_tag);
  assign w_last_beat = (r_beat == WORD_BITS'(LINE_WORDS - 1));
  // Byte offset within a word is irrelevant for 32-bit instruction loads.
  assign w_unused_addr_bits = ^load_addr_i[1:0];

  // The strobe must drop in the very cycle a redirect arrives, so it is
  // derived from the registered state and the live flush input.
  assign w_rdy       = (r_state == RESP) && !flush_i;
  assign load_rdy_o  = w_rdy;
  assign load_busy_o = (r_state != IDLE);
  assign mem_req_o   = r_mem_req;
  assign mem_addr_o  = r_mem_addr;
  // Present fresh data on the strobe, otherwise the last delivered word.
  assign load_insn_o = w_rdy ? r_line[r_word] : r_insn_hold;

  // Line storage carries no reset; r_line_valid qualifies it.
  always_ff @(posedge clk) begin
    if (r_state == FILL && mem_rvalid_i) begin
      r_line[r_beat] <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_line_valid <= 1'b0;
      r_line_tag   <= '0;
      r_beat       <= '0;
      r_word       <= '0;
      r_req_tag    <= '0;
      r_drop       <= 1'b0;
      r_insn_hold  <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_en_i) begin
            r_word    <= w_word;
            r_req_tag <= w_tag;
            if (w_hit) begin
              r_state <= RESP;
            end else begin
              r_state      <= REQ;
              r_mem_req    <= 1'b1;
              r_mem_addr   <= {w_tag, {OFF_BITS{1'b0}}};
              r_line_valid <= 1'b0;
            end
          end
        end
        REQ: begin
          if (flush_i) r_drop <= 1'b1;
          if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_beat    <= '0;
            r_state   <= FILL;
          end
        end
        FILL: begin
          if (flush_i) r_drop <= 1'b1;
          if (mem_rvalid_i) begin
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) begin
              r_line_valid <= 1'b1;
              r_line_tag   <= r_req_tag;
              // A flush coinciding with the final beat still drops.
              r_drop       <= 1'b0;
              r_state      <= (r_drop || flush_i) ? IDLE : RESP;
            end
          end
        end
        RESP: begin
          if (w_rdy) r_insn_hold <= r_line[r_word];
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_line_fetcher
//  Purpose  : Self-checking bench for imem_line_fetcher. Expected instructions
//             are queued when a load is issued; a monitor pops and compares on
//             every load_rdy_o strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_line_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] load_addr_i;
  logic        load_en_i;
  logic [31:0] load_insn_o;
  logic        load_busy_o;
  logic        load_rdy_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic prev_rdy = 1'b0;

  imem_line_fetcher #(.DATA_WIDTH(64), .LINE_WORDS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_addr_i  (load_addr_i),
    .load_en_i    (load_en_i),
    .load_insn_o  (load_insn_o),
    .load_busy_o  (load_busy_o),
    .load_rdy_o   (load_rdy_o),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every strobe against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (load_rdy_o && flush_i) begin
        checks++; errors++;
        $display("FAIL rdy_with_flush: got rdy=1 expected rdy=0");
      end
      if (load_rdy_o && prev_rdy) begin
        checks++; errors++;
        $display("FAIL consecutive_rdy: got two rdy cycles expected gap");
      end
      if (load_rdy_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rdy: got insn 0x%0h expected no rdy", load_insn_o);
        end else begin
          check("insn", {32'd0, load_insn_o}, {32'd0, exp_q.pop_front()});
        end
      end
      prev_rdy = load_rdy_o;
    end else begin
      prev_rdy = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [63:0] addr);
    load_addr_i = addr;
    load_en_i   = 1'b1;
    cyc();
    load_en_i   = 1'b0;
  endtask

  task automatic wait_req(input logic [63:0] exp_addr);
    int n = 0;
    while (!mem_req_o && n < 20) begin
      cyc();
      n++;
    end
    check("mem_req_seen", {63'd0, mem_req_o}, 64'd1);
    check("mem_addr", mem_addr_o, exp_addr);
  endtask

  task automatic grant(input int delay, input logic [63:0] exp_addr);
    repeat (delay) cyc();
    check("req_held", {63'd0, mem_req_o}, 64'd1);
    check("addr_held", mem_addr_o, exp_addr);
    mem_gnt_i = 1'b1;
    cyc();
    mem_gnt_i = 1'b0;
  endtask

  // Four ascending beats; optional flush-only cycle after beat flush_after.
  task automatic beats(input logic [31:0] base, input int flush_after);
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = base + i;
      cyc();
      mem_rvalid_i = 1'b0;
      if (i == flush_after) begin
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; load_addr_i = '0; load_en_i = 1'b0; flush_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, load_busy_o}, 64'd0);
    check("rst_rdy",  {63'd0, load_rdy_o},  64'd0);
    check("rst_req",  {63'd0, mem_req_o},   64'd0);
    check("rst_insn", {32'd0, load_insn_o}, 64'd0);
    check("rst_addr", mem_addr_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc();

    // Miss on 0x1004, grant after 2 cycles.
    accept(64'h1004);
    check("t1_busy_accept", {63'd0, load_busy_o}, 64'd1);
    wait_req(64'h1000);
    grant(2, 64'h1000);
    exp_q.push_back(32'hA1);
    beats(32'hA0, -1);
    check("t1_busy_rdy", {63'd0, load_busy_o}, 64'd1);
    cyc();
    check("t1_busy_done", {63'd0, load_busy_o}, 64'd0);

    // Hit on 0x100C.
    exp_q.push_back(32'hA3);
    accept(64'h100C);
    check("t2_no_req", {63'd0, mem_req_o}, 64'd0);
    check("t2_busy", {63'd0, load_busy_o}, 64'd1);
    cyc();
    check("t2_idle", {63'd0, load_busy_o}, 64'd0);

    // Back-to-back hits with en held high.
    exp_q.push_back(32'hA0);
    exp_q.push_back(32'hA1);
    exp_q.push_back(32'hA2);
    load_en_i = 1'b1; load_addr_i = 64'h1000;
    cyc();
    load_addr_i = 64'h1004;
    cyc();
    cyc();
    load_addr_i = 64'h1008;
    cyc();
    cyc();
    load_en_i = 1'b0;
    cyc();
    check("t3_no_req", {63'd0, mem_req_o}, 64'd0);

    // Miss on 0x2000 with a flush during FILL: no response.
    accept(64'h2000);
    wait_req(64'h2000);
    grant(1, 64'h2000);
    beats(32'hB0, 1);
    check("t4_busy_drop", {63'd0, load_busy_o}, 64'd0);
    exp_q.push_back(32'hB2);
    accept(64'h2008);
    check("t4_hit_no_req", {63'd0, mem_req_o}, 64'd0);
    cyc();

    // Hit whose RESP cycle coincides with a flush.
    accept(64'h2004);
    flush_i = 1'b1;
    @(negedge clk);
    check("t5_rdy_supp", {63'd0, load_rdy_o}, 64'd0);
    check("t5_busy", {63'd0, load_busy_o}, 64'd1);
    cyc();
    flush_i = 1'b0;
    check("t5_idle", {63'd0, load_busy_o}, 64'd0);
    check("t5_insn_hold", {32'd0, load_insn_o}, 64'hB2);

    // Reset in the middle of a refill.
    accept(64'h3000);
    wait_req(64'h3000);
    grant(0, 64'h3000);
    for (int i = 0; i < 2; i++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hC0 + i;
      cyc();
    end
    mem_rvalid_i = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_busy_rst", {63'd0, load_busy_o}, 64'd0);
    check("t6_req_rst", {63'd0, mem_req_o}, 64'd0);
    exp_q.push_back(32'hC1);
    accept(64'h3004);
    wait_req(64'h3000);
    grant(1, 64'h3000);
    beats(32'hC0, -1);
    cyc();
    cyc();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_line_fetcher.md
Name: imem_line_fetcher

Overview:
- Instruction-memory load unit directly upstream of the fetch unit.
- Serves the fetch unit's single-instruction load handshake (addr/en -> insn/rdy, busy) from a one-line instruction buffer.
- On a buffer miss, refills the whole line from the backing instruction memory over a request/grant plus in-order beat bus.
- Honours the branch-broadcast redirect by never returning an instruction in a redirect cycle and by discarding any response still owed.

Parameters:
- DATA_WIDTH, 64, address width.
- LINE_WORDS, 4, 32-bit words per line (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load_addr_i  in  DATA_WIDTH  instruction byte address; bits [1:0] ignored
- load_en_i  in  1  load request; accepted only when load_busy_o=0
- load_insn_o  out  32  returned instruction; valid when load_rdy_o=1
- load_busy_o  out  1  unit cannot accept a request
- load_rdy_o  out  1  one-cycle strobe: load_insn_o valid
- flush_i  in  1  redirect (branch broadcast); kills any pending response
- mem_req_o  out  1  line refill request
- mem_addr_o  out  DATA_WIDTH  line-aligned byte address of the refill
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  refill beat valid
- mem_rdata_i  in  32  refill beat data, ascending word order from the line base

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; line_valid=0; beat counter=0; drop flag=0.
  - Outputs: load_rdy_o=0, mem_req_o=0, load_busy_o=0, load_insn_o=0, mem_addr_o=0.
- Address split:
  - word = addr[$clog2(LINE_WORDS)+1:2].
  - tag = addr[DATA_WIDTH-1:$clog2(LINE_WORDS)+2].
  - Line base = addr with the low $clog2(LINE_WORDS)+2 bits zeroed.
- load_busy_o = (state != IDLE), combinational.
- States IDLE, REQ, FILL, RESP:
  - IDLE: load_en_i=1 latches the address.
    - Hit (line_valid and tag match) -> RESP.
    - Miss -> REQ, with mem_addr_o = line base and line_valid cleared.
  - REQ: mem_req_o=1 and mem_addr_o held stable until the cycle mem_gnt_i=1, then -> FILL with beat count 0.
  - FILL: each mem_rvalid_i=1 writes mem_rdata_i into line[beat] and increments beat.
    - On the beat with beat=LINE_WORDS-1: line_valid=1 and the tag is stored.
    - Then -> IDLE if drop=1 (clear drop), else -> RESP.
  - RESP: load_rdy_o = !flush_i; load_insn_o = line[latched word]; next state IDLE.
- Latency:
  - Hit: en accepted at cycle T gives rdy at T+1.
  - busy stays high in the rdy cycle, so the fetch unit cannot re-issue the stale PC. Sustained hit throughput is one instruction per 2 cycles.
  - Miss: rdy one cycle after the last refill beat.
- flush_i:
  - In IDLE: no effect.
  - In REQ or FILL: sets drop. The request and refill still complete (the bus cannot be abandoned) and the line becomes valid, but no rdy is produced.
  - In RESP: rdy suppressed that cycle.
  - load_rdy_o is never 1 in a cycle with flush_i=1.
  - A flush in the same cycle as the final beat still drops.
- Ignored inputs:
  - load_en_i while busy.
  - mem_gnt_i outside REQ.
  - mem_rvalid_i outside FILL.
- rst mid-refill returns to IDLE with line_valid=0. The backing memory is reset by the same rst.
- load_insn_o holds its last value when rdy=0.

Test Plan:
- Reset, then en with addr 0x1004; memory grants after 2 cycles and returns beats 0xA0,0xA1,0xA2,0xA3 -> mem_addr_o=0x1000; one rdy with insn 0xA1 on the cycle after beat 3; busy high from acceptance through that rdy cycle.
- Following en with addr 0x100C (hit) -> rdy next cycle with 0xA3; no mem_req_o.
- Back-to-back hits 0x1000, 0x1004, 0x1008 -> rdy every 2nd cycle; never two consecutive rdy cycles.
- Miss to 0x2000 with flush_i pulsed during FILL after beat 1 -> no rdy; busy drops after beat 3; a later en at 0x2008 hits with the beat-2 data.
- Hit issued, then flush_i=1 in the RESP cycle -> load_rdy_o=0; next cycle busy=0.
- rst asserted during FILL -> IDLE, busy=0; next en at the same line misses and re-requests.
